// File: rtl/jtframe_romrq_pkg.sv
// Shared types and constants for the jtframe ROM request cache.
package jtframe_romrq_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // Number of low address bits that pick a DW-wide lane inside a 32-bit line.
  function automatic int lane_shift(input int dw);
    return (dw == 8) ? 2 : (dw == 16) ? 1 : 0;
  endfunction

endpackage

// File: rtl/jtframe_romrq_line.sv
// One cache entry of jtframe_romrq_cache: valid/tag/data storage, hit compare
// and DW-wide lane multiplexer.
module jtframe_romrq_line
  import jtframe_romrq_pkg::*;
#(
  parameter int TW = 16,
  parameter int DW = 8
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                clr_i,
  input  logic                we_i,
  input  logic [TW-1:0]       wtag_i,
  input  logic [SDRAM_DW-1:0] wdata_i,
  input  logic [TW-1:0]       tag_i,
  input  logic [1:0]          lane_i,
  output logic                hit_o,
  output logic [DW-1:0]       lane_o
);

  logic                valid_q;
  logic [TW-1:0]       tag_q;
  logic [SDRAM_DW-1:0] data_q;
  logic [SDRAM_DW-1:0] shifted;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q <= 1'b0;
    else if (clr_i) valid_q <= 1'b0;
    else if (we_i)  valid_q <= 1'b1;
  end

  // NOTE: tag and data carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q  <= wtag_i;
      data_q <= wdata_i;
    end
  end

  assign hit_o   = valid_q && (tag_q == tag_i);
  assign shifted = data_q >> (int'(lane_i) * DW);
  assign lane_o  = shifted[DW-1:0];

endmodule

// File: rtl/jtframe_romrq_cache.sv
// ROM-region SDRAM initiator with a 2-line, LRU-replaced, 32-bit line cache.
// Optional miss counter on miss_cnt: define JTFRAME_ROMRQ_MISSCNT_EN.
module jtframe_romrq_cache
  import jtframe_romrq_pkg::*;
#(
  parameter int                  AW     = 18,
  parameter int                  DW     = 8,
  parameter logic [SDRAM_AW-1:0] OFFSET = 22'h0
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                clear,
  input  logic [AW-1:0]       addr,
  input  logic                addr_ok,
  output logic [DW-1:0]       dout,
  output logic                data_ok,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic [SDRAM_DW-1:0] data_read,
  input  logic                data_rdy,
  output logic [15:0]         miss_cnt
);

  localparam int SHIFT = lane_shift(DW);
  localparam int TW    = AW - SHIFT;

  state_t              state_q;
  logic [TW-1:0]       tag;
  logic [TW-1:0]       fetch_tag_q;
  logic [1:0]          lane;
  logic [1:0]          hit;
  logic [1:0]          we;
  logic [DW-1:0]       lane_data [2];
  logic                hit_any;
  logic                hit_idx;
  logic                fill;
  logic                miss_start;
  logic                lru_q;
  logic                discard_q;
  logic                data_ok_q;
  logic [DW-1:0]       dout_q;
  logic                sdram_req_q;
  logic [SDRAM_AW-1:0] sdram_addr_q;

  assign tag = addr[AW-1:SHIFT];

  if (SHIFT == 0) begin : g_word
    assign lane = 2'd0;
  end else begin : g_lane
    assign lane = 2'(addr[SHIFT-1:0]);
  end

  for (genvar i = 0; i < 2; i++) begin : g_line
    jtframe_romrq_line #(.TW(TW), .DW(DW)) u_line (
      .rst    (rst),
      .clk    (clk),
      .clr_i  (clear),
      .we_i   (we[i]),
      .wtag_i (fetch_tag_q),
      .wdata_i(data_read),
      .tag_i  (tag),
      .lane_i (lane),
      .hit_o  (hit[i]),
      .lane_o (lane_data[i])
    );
  end

  assign hit_any    = |hit;
  assign hit_idx    = ~hit[0];
  // A clear in the fill cycle or an earlier clear (discard) keeps the line out of the cache.
  assign fill       = (state_q == WAIT) && data_rdy && !discard_q && !clear;
  assign we         = fill ? (lru_q ? 2'b10 : 2'b01) : 2'b00;
  assign miss_start = (state_q == IDLE) && addr_ok && !hit_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lru_q        <= 1'b0;
      discard_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      dout_q       <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      fetch_tag_q  <= '0;
    end else begin
      data_ok_q <= addr_ok && hit_any && !clear;
      if (addr_ok && hit_any && !clear) dout_q <= hit[0] ? lane_data[0] : lane_data[1];

      if (fill)                    lru_q <= ~lru_q;
      else if (addr_ok && hit_any) lru_q <= ~hit_idx;

      case (state_q)
        IDLE: begin
          if (miss_start) begin
            state_q      <= REQ;
            fetch_tag_q  <= tag;
            sdram_req_q  <= 1'b1;
            sdram_addr_q <= OFFSET + (SDRAM_AW'(tag) << 1);
          end
        end
        REQ: begin
          if (clear) discard_q <= 1'b1;
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
          end else if (clear) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign data_ok    = data_ok_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

`ifdef JTFRAME_ROMRQ_MISSCNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           miss_cnt_q <= '0;
    else if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
  end

  assign miss_cnt = miss_cnt_q;
`else
  assign miss_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_jtframe_romrq_cache.sv
// Self-checking bench for jtframe_romrq_cache (DW=8): directed steps, then
// randomized accesses against a tag-level model of a 2-entry LRU cache.
module tb_jtframe_romrq_cache;

  localparam int          AW     = 18;
  localparam int          DW     = 8;
  localparam logic [21:0] OFFSET = 22'h100000;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [AW-1:0] addr;
  logic          addr_ok;
  logic [DW-1:0] dout;
  logic          data_ok;
  logic          sdram_req;
  logic          sdram_ack;
  logic [21:0]   sdram_addr;
  logic [31:0]   data_read;
  logic          data_rdy;
  logic [15:0]   miss_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: which tags sit in which entry, and which entry is the victim.
  bit          m_valid [2];
  logic [15:0] m_tag   [2];
  bit          m_lru;
  int          m_misses;

  always #5 clk = ~clk;

  jtframe_romrq_cache #(.AW(AW), .DW(DW), .OFFSET(OFFSET)) dut (
    .rst       (rst),
    .clk       (clk),
    .clear     (clear),
    .addr      (addr),
    .addr_ok   (addr_ok),
    .dout      (dout),
    .data_ok   (data_ok),
    .sdram_req (sdram_req),
    .sdram_ack (sdram_ack),
    .sdram_addr(sdram_addr),
    .data_read (data_read),
    .data_rdy  (data_rdy),
    .miss_cnt  (miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Backing ROM content: tag 1 holds the documented example line.
  function automatic logic [31:0] mem_word(input logic [15:0] t);
    if (t == 16'd1) return 32'hDDCCBBAA;
    return {t ^ 16'hC3A5, ~t};
  endfunction

  function automatic logic [7:0] lane_of(input logic [17:0] a);
    logic [31:0] w;
    w = mem_word(a[17:2]);
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  function automatic logic [21:0] line_addr(input logic [15:0] t);
    return 22'((int'(OFFSET) + 2 * int'(t)) % (1 << 22));
  endfunction

  function automatic int lookup(input logic [15:0] t);
    for (int i = 0; i < 2; i++)
      if (m_valid[i] && m_tag[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef JTFRAME_ROMRQ_MISSCNT_EN
    return (m_misses > 65535) ? 16'hFFFF : 16'(m_misses);
`else
    return 16'h0;
`endif
  endfunction

  // Runs one outstanding fetch from the cycle sdram_req is first seen high
  // until data_ok is expected; optional data_rdy pulse while still in REQ,
  // optional clear while waiting for data.
  task automatic serve(input logic [15:0] t, input int ack_dly, input bit spurious, input bit clr_wait);
    for (int k = 0; k < ack_dly; k++) begin
      data_rdy  = spurious && (k == 0);
      data_read = 32'h0BAD0BAD;
      step();
      data_rdy = 1'b0;
      check("req_hold", sdram_req, 1);
      check("addr_hold", sdram_addr, line_addr(t));
      check("busy_ok", data_ok, 0);
    end
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    check("req_drop", sdram_req, 0);
    clear = clr_wait;
    step();
    clear = 1'b0;
    if (clr_wait) begin
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
    end
    check("wait_ok", data_ok, 0);
    data_read = mem_word(t);
    data_rdy  = 1'b1;
    step();
    data_rdy  = 1'b0;
    data_read = 32'hF00DF00D;
    check("rdy_ok", data_ok, 0);
    if (clr_wait) begin
      check("discard_noreq", sdram_req, 0);
      m_misses++;
      step();
      check("reissue_ok", data_ok, 0);
      check("reissue_req", sdram_req, 1);
      check("reissue_addr", sdram_addr, line_addr(t));
      serve(t, 1, 1'b0, 1'b0);
    end else begin
      m_valid[m_lru] = 1'b1;
      m_tag[m_lru]   = t;
      m_lru          = ~m_lru;
      step();
    end
  endtask

  task automatic access(input logic [17:0] a, input int ack_dly, input bit spurious, input bit clr_wait);
    logic [15:0] t;
    int          e;
    t       = a[17:2];
    e       = lookup(t);
    addr    = a;
    addr_ok = 1'b1;
    step();
    if (e >= 0) begin
      check("hit_ok", data_ok, 1);
      check("hit_dout", dout, lane_of(a));
      check("hit_noreq", sdram_req, 0);
      m_lru = (e == 0);
    end else begin
      m_misses++;
      check("miss_req", sdram_req, 1);
      check("miss_addr", sdram_addr, line_addr(t));
      serve(t, ack_dly, spurious, clr_wait);
      check("fill_ok", data_ok, 1);
      check("fill_dout", dout, lane_of(a));
    end
    check("miss_cnt", miss_cnt, exp_cnt());
    addr_ok = 1'b0;
    step();
    check("idle_ok", data_ok, 0);
  endtask

  // One cycle of clear in IDLE; addr_ok is only raised when the address hits.
  task automatic clear_cycle(input logic [17:0] a, input bit aok);
    int e;
    e       = lookup(a[17:2]);
    addr    = a;
    addr_ok = aok && (e >= 0);
    clear   = 1'b1;
    if (addr_ok) m_lru = (e == 0);
    step();
    clear      = 1'b0;
    addr_ok    = 1'b0;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    check("clear_ok", data_ok, 0);
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    addr      = '0;
    addr_ok   = 1'b0;
    sdram_ack = 1'b0;
    data_read = '0;
    data_rdy  = 1'b0;
    m_valid   = '{1'b0, 1'b0};
    m_tag     = '{16'h0, 16'h0};
    m_lru     = 1'b0;
    m_misses  = 0;

    #12;
    check("rst_data_ok", data_ok, 0);
    check("rst_dout", dout, 0);
    check("rst_req", sdram_req, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_ok", data_ok, 0);

    // Example line fetch, lane select, LRU eviction and 3-miss/5-hit count.
    access(18'd5, 2, 1'b0, 1'b0);
    check("ex_dout_bb", dout, 8'hBB);
    access(18'd7, 0, 1'b0, 1'b0);
    check("ex_dout_dd", dout, 8'hDD);
    access(18'd8, 0, 1'b0, 1'b0);
    access(18'd4, 0, 1'b0, 1'b0);
    access(18'd13, 1, 1'b0, 1'b0);
    access(18'd6, 0, 1'b0, 1'b0);
    access(18'd14, 0, 1'b0, 1'b0);
    access(18'd5, 0, 1'b0, 1'b0);
`ifdef JTFRAME_ROMRQ_MISSCNT_EN
    check("cnt_3m5h", miss_cnt, 3);
`else
    check("cnt_3m5h", miss_cnt, 0);
`endif

    // Tag 2 was evicted by tag 3; long ack stall with a stray data_rdy in REQ.
    access(18'd9, 10, 1'b1, 1'b0);
    check("tag2_addr", sdram_addr, OFFSET + 22'd4);

    // Clear while waiting for data, then hit together with clear.
    access(18'd20, 1, 1'b0, 1'b1);
    clear_cycle(18'd21, 1'b1);
    access(18'd21, 0, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) clear_cycle(18'($urandom_range(23)), 1'b0);
      access(18'($urandom_range(23)), int'($urandom_range(3)), 1'($urandom_range(1)),
             $urandom_range(9) == 0);
    end
    check("cnt_final", miss_cnt, exp_cnt());

    // Reset in the middle of a fetch drops the request without waiting for an edge.
    clear_cycle(18'd0, 1'b0);
    addr    = 18'd40;
    addr_ok = 1'b1;
    step();
    check("pre_rst_req", sdram_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_drop_req", sdram_req, 0);
    check("rst_drop_ok", data_ok, 0);
    addr_ok = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
